// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared types and constants for the LED pattern driver.
//   - led_pattern_e   : pattern generator mode (STATIC/BLINK/BREATHE/CHASE)
//   - led_colour_e    : colour select (R/G/B/WHITE)
//   - breathe_state_e : breathe ramp direction (UP/DOWN)
//   - PwmWDefault     : default duty/level width
//   - colour_mask()   : colour select -> {B,G,R} channel mask
//   - cie_lut()       : CIE1931 lightness table entry, evaluated at elaboration
//                       time to build the brightness-correction ROM
//                       (only instantiated when LED_CIE_LUT_EN is defined)
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int unsigned PwmWDefault = 8;

    typedef enum logic [1:0] {
        PatStatic  = 2'd0,
        PatBlink   = 2'd1,
        PatBreathe = 2'd2,
        PatChase   = 2'd3
    } led_pattern_e;

    typedef enum logic [1:0] {
        ColR     = 2'd0,
        ColG     = 2'd1,
        ColB     = 2'd2,
        ColWhite = 2'd3
    } led_colour_e;

    typedef enum logic {
        BreatheUp   = 1'b0,
        BreatheDown = 1'b1
    } breathe_state_e;

    // Output bit order is {B,G,R}.
    function automatic logic [2:0] colour_mask(led_colour_e colour);
        logic [2:0] mask;
        mask = 3'b000;
        unique case (colour)
            ColR:     mask = 3'b001;
            ColG:     mask = 3'b010;
            ColB:     mask = 3'b100;
            ColWhite: mask = 3'b111;
        endcase
        return mask;
    endfunction

    // CIE1931: L* = 100*n/max; Y = L*/903.3 for L* <= 8, else ((L*+16)/116)^3.
    // Result is round(max*Y) in exact integer arithmetic, so lut(0)=0 and
    // lut(max)=max hold exactly. The 64-bit intermediates cover pwm_w <= 12.
    function automatic int unsigned cie_lut(int unsigned level, int unsigned pwm_w);
        longint unsigned m;
        longint unsigned n;
        longint unsigned base;
        longint unsigned num;
        longint unsigned den;
        m = (64'd1 << pwm_w) - 64'd1;
        n = 64'(level);
        if (100 * n <= 8 * m) begin
            return int'((1000 * n + 64'd4516) / 64'd9033);
        end
        base = 100 * n + 16 * m;
        num  = base * base * base;
        den  = 64'd1560896 * m * m;
        return int'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/led_pattern_driver_if.sv
// -----------------------------------------------------------------------------
// led_pattern_driver_if
//   Control fields from the LED register file and the PWM pin outputs.
//   master : register-file side (drives controls, observes outputs)
//   slave  : led_pattern_driver side
//   Signals:
//     led_select[1:0]   colour 0=R 1=G 2=B 3=white
//     led16_on_off      LED16 enable
//     led17_on_off      LED17 enable
//     led16_cie_on_off  LED16 CIE correction enable
//     led17_cie_on_off  LED17 CIE correction enable
//     pattern_mode[1:0] 0=STATIC 1=BLINK 2=BREATHE 3=CHASE
//     led16_rgb[2:0]    {B,G,R} PWM pins LED16
//     led17_rgb[2:0]    {B,G,R} PWM pins LED17
//     period_strobe     pulse on last clk of each PWM period
// -----------------------------------------------------------------------------
interface led_pattern_driver_if;

    logic [1:0] led_select;
    logic       led16_on_off;
    logic       led17_on_off;
    logic       led16_cie_on_off;
    logic       led17_cie_on_off;
    logic [1:0] pattern_mode;
    logic [2:0] led16_rgb;
    logic [2:0] led17_rgb;
    logic       period_strobe;

    modport master (
        output led_select,
        output led16_on_off,
        output led17_on_off,
        output led16_cie_on_off,
        output led17_cie_on_off,
        output pattern_mode,
        input  led16_rgb,
        input  led17_rgb,
        input  period_strobe
    );

    modport slave (
        input  led_select,
        input  led16_on_off,
        input  led17_on_off,
        input  led16_cie_on_off,
        input  led17_cie_on_off,
        input  pattern_mode,
        output led16_rgb,
        output led17_rgb,
        output period_strobe
    );

endinterface

// File: rtl/led_pwm_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_channel
//   One RGB LED: level (+ optional CIE correction) -> registered duty ->
//   registered 3-bit PWM output.
//   Build option: LED_CIE_LUT_EN adds the CIE1931 ROM and the cie_en port;
//   without it duty is the linear level.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     level[PWM_W]      brightness level for the current period
//     cie_en            select CIE-corrected duty (LED_CIE_LUT_EN only)
//     led_en            LED enable
//     colour            colour select
//     pwm_cnt[PWM_W]    shared PWM step counter
//     rgb[2:0]          {B,G,R} PWM output, registered
// -----------------------------------------------------------------------------
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_W = PwmWDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] level,
`ifdef LED_CIE_LUT_EN
    input  logic             cie_en,
`endif
    input  logic             led_en,
    input  led_colour_e      colour,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic [2:0]       rgb
);

    localparam logic [PWM_W-1:0] DutyMax = '1;

    logic [PWM_W-1:0] duty_d;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] cnt_q;
    logic             en_q;
    logic [2:0]       mask_q;
    logic             lit;
    logic [2:0]       rgb_d;
    logic [2:0]       rgb_q;

`ifdef LED_CIE_LUT_EN
    localparam int unsigned NumLevels = 2 ** PWM_W;

    logic [PWM_W-1:0] cie_rom [NumLevels];

    for (genvar i = 0; i < NumLevels; i++) begin : g_cie_rom
        assign cie_rom[i] = PWM_W'(cie_lut(i, PWM_W));
    end

    assign duty_d = cie_en ? cie_rom[level] : level;
`else
    assign duty_d = level;
`endif

    // Stage 1: duty, counter and gating are captured together so the compare
    // below always sees a consistent period/step pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            mask_q <= 3'b000;
        end else begin
            duty_q <= duty_d;
            cnt_q  <= pwm_cnt;
            en_q   <= led_en;
            mask_q <= colour_mask(colour);
        end
    end

    // Full-scale duty is always on; zero duty never lights.
    always_comb begin
        lit   = (duty_q == DutyMax) || (cnt_q < duty_q);
        rgb_d = (en_q && lit) ? mask_q : 3'b000;
    end

    // Stage 2: registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 3'b000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/led_pattern_driver.sv
// -----------------------------------------------------------------------------
// led_pattern_driver
//   Drives the two RGB LEDs (LED16/LED17) with PWM from the LED register-file
//   control fields. Patterns: static, blink, breathe, chase. All controls are
//   shadowed at PWM period boundaries so a register write never glitches a
//   period. A change of shadowed pattern mode restarts the pattern state.
//   Build option: LED_CIE_LUT_EN enables the CIE1931 brightness ROM; when
//   undefined the cie_on_off fields are ignored and duty is linear.
//   Parameters:
//     CLK_DIV        clk cycles per PWM step (>=1)
//     PWM_W          duty/level and PWM counter width
//     BLINK_PERIODS  PWM periods per blink/chase half-phase (>=1)
//     BREATHE_STEP   PWM periods per breathe level step (>=1)
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     bus            led_pattern_driver_if.slave (controls in, pins/strobe out)
// -----------------------------------------------------------------------------
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 390,
    parameter int unsigned PWM_W         = PwmWDefault,
    parameter int unsigned BLINK_PERIODS = 500,
    parameter int unsigned BREATHE_STEP  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    led_pattern_driver_if.slave bus
);

    localparam int unsigned PrescW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam int unsigned StepW  = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;

    localparam logic [PrescW-1:0] PrescLast  = PrescW'(CLK_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast  = BlinkW'(BLINK_PERIODS - 1);
    localparam logic [StepW-1:0]  StepLast   = StepW'(BREATHE_STEP - 1);
    localparam logic [PWM_W-1:0]  LevelMax   = '1;
    localparam logic [PWM_W-1:0]  LevelOne   = PWM_W'(1);
    localparam logic [PWM_W-1:0]  LevelPenul = LevelMax - LevelOne;

    // Timebase
    logic [PrescW-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic              tick;
    logic              strobe;

    // Shadow registers
    led_pattern_e mode_q, mode_d;
    led_colour_e  sel_q, sel_d;
    logic         en16_q, en16_d;
    logic         en17_q, en17_d;

    // Pattern state
    logic           phase_q, phase_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic [StepW-1:0]  step_cnt_q, step_cnt_d;
    logic [PWM_W-1:0]  level_q, level_d;
    breathe_state_e    br_state_q, br_state_d;

    led_pattern_e     mode_in;
    logic [PWM_W-1:0] level16;
    logic [PWM_W-1:0] level17;
    logic [2:0]       led16_rgb;
    logic [2:0]       led17_rgb;

    // -------------------------------------------------------------------------
    // Prescaler and PWM step counter
    // -------------------------------------------------------------------------
    assign tick   = (presc_q == PrescLast);
    assign strobe = tick && (pwm_cnt_q == LevelMax);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow load and pattern advance, both only on the period strobe
    // -------------------------------------------------------------------------
    assign mode_in = led_pattern_e'(bus.pattern_mode);

    always_comb begin
        mode_d      = mode_q;
        sel_d       = sel_q;
        en16_d      = en16_q;
        en17_d      = en17_q;
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        step_cnt_d  = step_cnt_q;
        level_d     = level_q;
        br_state_d  = br_state_q;

        if (strobe) begin
            mode_d = mode_in;
            sel_d  = led_colour_e'(bus.led_select);
            en16_d = bus.led16_on_off;
            en17_d = bus.led17_on_off;

            if (mode_in != mode_q) begin
                // New pattern starts from a clean state in the same period.
                phase_d     = 1'b0;
                blink_cnt_d = '0;
                step_cnt_d  = '0;
                level_d     = '0;
                br_state_d  = BreatheUp;
            end else begin
                unique case (mode_q)
                    PatBlink, PatChase: begin
                        if (blink_cnt_q == BlinkLast) begin
                            blink_cnt_d = '0;
                            phase_d     = ~phase_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 1'b1;
                        end
                    end
                    PatBreathe: begin
                        if (step_cnt_q == StepLast) begin
                            step_cnt_d = '0;
                            unique case (br_state_q)
                                BreatheUp: begin
                                    if (level_q != LevelMax) begin
                                        level_d = level_q + 1'b1;
                                    end
                                    if (level_q >= LevelPenul) begin
                                        br_state_d = BreatheDown;
                                    end
                                end
                                BreatheDown: begin
                                    if (level_q != '0) begin
                                        level_d = level_q - 1'b1;
                                    end
                                    if (level_q <= LevelOne) begin
                                        br_state_d = BreatheUp;
                                    end
                                end
                            endcase
                        end else begin
                            step_cnt_d = step_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= PatStatic;
            sel_q       <= ColR;
            en16_q      <= 1'b0;
            en17_q      <= 1'b0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
            step_cnt_q  <= '0;
            level_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            en16_q      <= en16_d;
            en17_q      <= en17_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            step_cnt_q  <= step_cnt_d;
            level_q     <= level_d;
        end
    end

    // Breathe direction FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_state_q <= BreatheUp;
        end else begin
            br_state_q <= br_state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-LED level for the current period
    // -------------------------------------------------------------------------
    always_comb begin
        level16 = LevelMax;
        level17 = LevelMax;
        unique case (mode_q)
            PatStatic: begin
                level16 = LevelMax;
                level17 = LevelMax;
            end
            PatBlink: begin
                level16 = phase_q ? LevelMax : '0;
                level17 = phase_q ? LevelMax : '0;
            end
            PatBreathe: begin
                level16 = level_q;
                level17 = level_q;
            end
            PatChase: begin
                level16 = phase_q ? LevelMax : '0;
                level17 = phase_q ? '0 : LevelMax;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // CIE select shadows
    // -------------------------------------------------------------------------
`ifdef LED_CIE_LUT_EN
    logic cie16_q;
    logic cie17_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cie16_q <= 1'b0;
            cie17_q <= 1'b0;
        end else if (strobe) begin
            cie16_q <= bus.led16_cie_on_off;
            cie17_q <= bus.led17_cie_on_off;
        end
    end
`else
    // No ROM in this build: the CIE enables have no effect.
    logic unused_cie;
    assign unused_cie = bus.led16_cie_on_off ^ bus.led17_cie_on_off;
`endif

    // -------------------------------------------------------------------------
    // PWM channels
    // -------------------------------------------------------------------------
    led_pwm_channel #(
        .PWM_W (PWM_W)
    ) u_led16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (level16),
`ifdef LED_CIE_LUT_EN
        .cie_en  (cie16_q),
`endif
        .led_en  (en16_q),
        .colour  (sel_q),
        .pwm_cnt (pwm_cnt_q),
        .rgb     (led16_rgb)
    );

    led_pwm_channel #(
        .PWM_W (PWM_W)
    ) u_led17 (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (level17),
`ifdef LED_CIE_LUT_EN
        .cie_en  (cie17_q),
`endif
        .led_en  (en17_q),
        .colour  (sel_q),
        .pwm_cnt (pwm_cnt_q),
        .rgb     (led17_rgb)
    );

    assign bus.led16_rgb     = led16_rgb;
    assign bus.led17_rgb     = led17_rgb;
    assign bus.period_strobe = strobe;

endmodule

// File: tb/tb_led_pattern_driver.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_driver
//   Scoreboard bench for led_pattern_driver (CLK_DIV=1, PWM_W=8,
//   BLINK_PERIODS=2, BREATHE_STEP=1; 256-clk PWM period).
//   A reference model samples the controls at every period strobe and queues
//   the expected per-pin high-time for the next period; a monitor integrates
//   each pin over every output period and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_led_pattern_driver;

    localparam int unsigned ClkDiv       = 1;
    localparam int unsigned PwmW         = 8;
    localparam int unsigned BlinkPeriods = 2;
    localparam int unsigned BreatheStep  = 1;
    localparam int unsigned PeriodClks   = 256;

    // {led17 B,G,R, led16 B,G,R}: high clocks per PWM period
    typedef logic [5:0][8:0] counts_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_pattern_driver_if bus ();

    led_pattern_driver #(
        .CLK_DIV       (ClkDiv),
        .PWM_W         (PwmW),
        .BLINK_PERIODS (BlinkPeriods),
        .BREATHE_STEP  (BreatheStep)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    counts_t     exp_q [$];

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: pattern level as a closed-form function of the number
    // of periods n since the current mode was loaded.
    // ---------------------------------------------------------------------
    function automatic int unsigned ref_level(int unsigned mode, int unsigned n, bit is17);
        int unsigned phase;
        int unsigned k;
        phase = (n / BlinkPeriods) % 2;
        k     = (n / BreatheStep) % 510;
        case (mode)
            0:       return 255;
            1:       return (phase != 0) ? 255 : 0;
            2:       return (k <= 255) ? k : 510 - k;
            default: return ((phase != 0) ^ is17) ? 255 : 0;
        endcase
    endfunction

    function automatic int unsigned ref_duty(int unsigned level, bit cie);
`ifdef LED_CIE_LUT_EN
        real l;
        real t;
        real y;
        if (cie) begin
            l = 100.0 * real'(level) / 255.0;
            if (l <= 8.0) begin
                y = l / 903.3;
            end else begin
                t = (l + 16.0) / 116.0;
                y = t * t * t;
            end
            return int'($rtoi(255.0 * y + 0.5));
        end
        return level;
`else
        if (cie) return level;
        return level;
`endif
    endfunction

    function automatic counts_t ref_counts(int unsigned mode, int unsigned n, int unsigned sel,
                                           bit e16, bit e17, bit c16, bit c17);
        counts_t     c;
        int unsigned on_clks;
        bit          en;
        c = '0;
        for (int led = 0; led < 2; led++) begin
            en      = (led == 0) ? e16 : e17;
            on_clks = ref_duty(ref_level(mode, n, led == 1), (led == 0) ? c16 : c17);
            if (on_clks == 255) on_clks = PeriodClks;
            for (int b = 0; b < 3; b++) begin
                if (en && (sel == 3 || sel == b)) c[led * 3 + b] = 9'(on_clks);
            end
        end
        return c;
    endfunction

    // Model: push one expectation per output period.
    initial begin : model
        int unsigned m_mode;
        int unsigned m_n;
        int unsigned m_sel;
        bit          m_e16, m_e17, m_c16, m_c17;
        bit          need_init;
        need_init = 1'b1;
        m_mode = 0; m_n = 0; m_sel = 0;
        m_e16 = 0; m_e17 = 0; m_c16 = 0; m_c17 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                need_init = 1'b1;
                continue;
            end
            if (need_init) begin
                need_init = 1'b0;
                m_mode = 0; m_n = 0; m_sel = 0;
                m_e16 = 0; m_e17 = 0; m_c16 = 0; m_c17 = 0;
                exp_q.push_back(ref_counts(m_mode, m_n, m_sel, m_e16, m_e17, m_c16, m_c17));
            end
            if (bus.period_strobe) begin
                if (int'(bus.pattern_mode) != m_mode) begin
                    m_mode = bus.pattern_mode;
                    m_n    = 0;
                end else begin
                    m_n++;
                end
                m_sel = bus.led_select;
                m_e16 = bus.led16_on_off;
                m_e17 = bus.led17_on_off;
                m_c16 = bus.led16_cie_on_off;
                m_c17 = bus.led17_cie_on_off;
                exp_q.push_back(ref_counts(m_mode, m_n, m_sel, m_e16, m_e17, m_c16, m_c17));
            end
        end
    end

    // Monitor: output period k begins 3 clocks after the strobe that opened it.
    initial begin : monitor
        counts_t     win;
        logic [2:0]  hist;
        int unsigned idx;
        int unsigned next_strobe;
        win = '0; hist = '0; idx = 0; next_strobe = PeriodClks - 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                win = '0; hist = '0; idx = 0; next_strobe = PeriodClks - 1;
                continue;
            end
            if (hist[2]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL period_counts: got a closed period, want a queued expectation");
                end else begin
                    check_val("period_counts", 64'(win), 64'(exp_q.pop_front()));
                end
                win = '0;
            end
            for (int b = 0; b < 3; b++) begin
                win[b]     = win[b] + 9'(bus.led16_rgb[b]);
                win[3 + b] = win[3 + b] + 9'(bus.led17_rgb[b]);
            end
            if (bus.period_strobe) begin
                check_val("strobe_cycle", 64'(idx), 64'(next_strobe));
                next_strobe = idx + PeriodClks;
            end else if (idx == next_strobe) begin
                check_val("strobe_present", 64'(bus.period_strobe), 64'd1);
                next_strobe = idx + PeriodClks;
            end
            hist = {hist[1:0], bus.period_strobe};
            idx++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus: all drives happen 2 time units after a rising edge.
    // ---------------------------------------------------------------------
    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input int unsigned mode, input int unsigned sel, input bit e16,
                         input bit e17, input bit c16, input bit c17);
        bus.pattern_mode     = 2'(mode);
        bus.led_select       = 2'(sel);
        bus.led16_on_off     = e16;
        bus.led17_on_off     = e17;
        bus.led16_cie_on_off = c16;
        bus.led17_cie_on_off = c17;
    endtask

    // Apply a setting at a random point inside a period and hold it.
    task automatic segment(input int unsigned mode, input int unsigned sel, input bit e16,
                           input bit e17, input bit c16, input bit c17, input int unsigned nper);
        wait_clks($urandom_range(1, PeriodClks - 1));
        drive(mode, sel, e16, e17, c16, c17);
        wait_clks(nper * PeriodClks);
    endtask

    initial begin : stimulus
        bit seen_lit;
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        wait_clks(4);
        @(negedge clk);
        check_val("reset_led16_rgb", 64'(bus.led16_rgb), 64'd0);
        check_val("reset_led17_rgb", 64'(bus.led17_rgb), 64'd0);
        check_val("reset_strobe", 64'(bus.period_strobe), 64'd0);
        wait_clks(1);
        rst_n = 1'b1;

        // Directed patterns
        segment(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4);  // STATIC red on LED16 only
        segment(1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 6);  // BLINK white on both
        segment(3, 1, 1'b1, 1'b1, 1'b0, 1'b0, 6);  // CHASE green

        // Random settings, each written mid-period
        for (int s = 0; s < 4; s++) begin
            segment($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(2, 5));
        end

        // BREATHE, then async reset while a pin is lit
        segment(2, 3, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30);
        seen_lit = 1'b0;
        for (int i = 0; i < 2 * PeriodClks; i++) begin
            @(posedge clk);
            #3;
            if (bus.led16_rgb != 3'b000) begin
                seen_lit = 1'b1;
                break;
            end
        end
        check_val("breathe_lit_before_reset", 64'(seen_lit), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_reset_led16_rgb", 64'(bus.led16_rgb), 64'd0);
        check_val("async_reset_led17_rgb", 64'(bus.led17_rgb), 64'd0);
        check_val("async_reset_strobe", 64'(bus.period_strobe), 64'd0);
        wait_clks(3);
        rst_n = 1'b1;

        // Full ramp up through the peak and into the down slope
        wait_clks(258 * PeriodClks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
